lane_traffic_gen: RTL

Traffic lane generator for the Frogger playfield. It consumes the 6-bit pseudo-random word from the upstream LFSR and produces a WIDTH-bit occupancy row (one bit per LED column) that scrolls one column per tick. Car length and spawn density come from the random word, with a minimum gap enforced between cars. It also reports a collision when the frog stands on an occupied column of this lane. The display driver instantiates one instance per road row.

---
 rtl/frogger_pkg.sv | 24 ++
 rtl/lane_tick_gen.sv | 53 +++++
 rtl/lane_traffic_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and helpers for the Frogger lane and display blocks.
package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        FREEZE = 2'd3
    } lane_state_t;

    localparam int CAR_REM_W = 2;

    // Car length 1..3 from the two length-select bits of the LFSR word; bit 1 dominates.
    function automatic logic [CAR_REM_W-1:0] car_len(input logic [1:0] len_sel);
        if (len_sel[1]) begin
            return CAR_REM_W'(3);
        end
        if (len_sel[0]) begin
            return CAR_REM_W'(2);
        end
        return CAR_REM_W'(1);
    endfunction

endpackage

// File: rtl/lane_tick_gen.sv
// Scroll-period counter: counts 0..PERIOD-1 while running, holds otherwise,
// and emits a registered one-cycle tick after each wrap edge.
module lane_tick_gen #(
    parameter int PERIOD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    input  logic suppress,
    output logic at_wrap,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;
    logic             tick_q;
    logic             tick_d;

    assign at_wrap = run && (tick_cnt_q == CNT_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (restart) begin
            tick_cnt_d = '0;
        end else if (run) begin
            if (tick_cnt_q == CNT_LAST) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
            // A wrap edge claimed by a clear or a collision does not count as a scroll.
            tick_d = at_wrap && !suppress;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lane_traffic_gen.sv
// Scrolling traffic lane for the Frogger playfield: spawns cars from the LFSR word,
// scrolls them one column per tick and freezes on a frog collision.
module lane_traffic_gen
    import frogger_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PERIOD  = 4,
    parameter int DENSITY = 8,
    parameter int MIN_GAP = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [5:0]               rnd,
    input  logic                     enable,
    input  logic                     dir,
    input  logic [$clog2(WIDTH)-1:0] frog_col,
    input  logic                     frog_in_lane,
    input  logic                     clear,
    output logic [WIDTH-1:0]         lane,
    output logic                     tick,
    output logic                     hit
);

    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
    localparam logic [4:0] DENSITY_THR = 5'(DENSITY);

    lane_state_t            state_q;
    lane_state_t            state_d;
    logic [WIDTH-1:0]       lane_q;
    logic [WIDTH-1:0]       lane_d;
    logic                   hit_q;
    logic                   hit_d;
    logic [CAR_REM_W-1:0]   car_rem_q;
    logic [CAR_REM_W-1:0]   car_rem_d;
    logic [GAP_W-1:0]       gap_q;
    logic [GAP_W-1:0]       gap_d;

    logic                   at_wrap;
    logic                   frog_on_car;
    logic                   hit_cond;
    logic                   entry;
    logic [CAR_REM_W-1:0]   car_rem_nxt;
    logic [GAP_W-1:0]       gap_nxt;
    logic [WIDTH-1:0]       lane_shift;

    lane_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .run      (state_q == RUN),
        .restart  (state_q == IDLE),
        .suppress (clear || hit_cond),
        .at_wrap  (at_wrap),
        .tick     (tick)
    );

    // Columns beyond the lane (possible when WIDTH is not a power of two) never collide.
    always_comb begin
        frog_on_car = 1'b0;
        if (int'(frog_col) < WIDTH) begin
            frog_on_car = lane_q[frog_col];
        end
        hit_cond = ((state_q == RUN) || (state_q == PAUSE)) && frog_in_lane && frog_on_car;
    end

    // Entry column value for the next scroll: finish the current car first, otherwise
    // spawn only once the gap behind the previous car is wide enough.
    always_comb begin
        entry       = 1'b0;
        car_rem_nxt = car_rem_q;
        gap_nxt     = gap_q;
        if (car_rem_q != '0) begin
            entry       = 1'b1;
            car_rem_nxt = car_rem_q - CAR_REM_W'(1);
        end else if ((gap_q >= GAP_MAX) && ({1'b0, rnd[3:0]} < DENSITY_THR)) begin
            entry       = 1'b1;
            car_rem_nxt = car_len(rnd[5:4]) - CAR_REM_W'(1);
        end
        if (entry) begin
            gap_nxt = '0;
        end else if (gap_q < GAP_MAX) begin
            gap_nxt = gap_q + GAP_W'(1);
        end
        lane_shift = dir ? {entry, lane_q[WIDTH-1:1]} : {lane_q[WIDTH-2:0], entry};
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        hit_d     = hit_q;
        car_rem_d = car_rem_q;
        gap_d     = gap_q;
        if (clear) begin
            state_d   = IDLE;
            lane_d    = '0;
            hit_d     = 1'b0;
            car_rem_d = '0;
            gap_d     = GAP_MAX;
        end else if (hit_cond) begin
            state_d = FREEZE;
            hit_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    lane_d = '0;
                    if (enable) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (at_wrap) begin
                        lane_d    = lane_shift;
                        car_rem_d = car_rem_nxt;
                        gap_d     = gap_nxt;
                    end
                    if (!enable) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (enable) begin
                        state_d = RUN;
                    end
                end
                FREEZE: begin
                    state_d = FREEZE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            hit_q     <= 1'b0;
            car_rem_q <= '0;
            gap_q     <= GAP_MAX;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            hit_q     <= hit_d;
            car_rem_q <= car_rem_d;
            gap_q     <= gap_d;
        end
    end

    assign lane = lane_q;
    assign hit  = hit_q;

endmodule
